// File: rtl/timer_icb_regif.sv
// ICB register interface for a 16-bit timer: CON/PRD/CNT pass-through with write strobes,
// sticky STAT flags with write-1-to-clear, IEN mask and a registered interrupt request.
module timer_icb_regif #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [ADDR_W-1:0] icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [31:0]       icb_cmd_wdata,
  input  logic [3:0]        icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic [31:0]       icb_rsp_rdata,
  output logic              icb_rsp_err,
  output logic              tmr_con_wr,
  output logic              tmr_prd_wr,
  output logic              tmr_cnt_wr,
  output logic [15:0]       icb_wdat,
  input  logic [15:0]       tmr_con,
  input  logic [15:0]       tmr_prd,
  input  logic [15:0]       tmr_cnt,
  input  logic              tmr_ovf,
  input  logic              tmr_int,
  output logic              irq
);

  localparam int unsigned IDX_W   = 3;
  localparam int unsigned ADDR_HI = 20;

  typedef enum logic {IDLE, RESP} state_e;

  state_e           state_q, state_d;
  logic             accept;
  logic             addr_ok;
  logic             wmask_ok;
  logic             wr_ok;
  logic             err_c;
  logic [IDX_W-1:0] reg_idx;
  logic [15:0]      rd_val;
  logic [1:0]       stat_q, ien_q, stat_clr;
  logic             con_wr_q, prd_wr_q, cnt_wr_q;
  logic             unused_bits;

  assign unused_bits = ^{icb_cmd_wdata[31:16], icb_cmd_wmask[3:2]};

  assign icb_cmd_ready = (state_q == IDLE) && !sys_rst;
  assign accept        = icb_cmd_valid && icb_cmd_ready;

  // Address/mask decode of the command being presented
  assign addr_ok  = (icb_cmd_addr[1:0] == 2'b00) && (icb_cmd_addr < ADDR_W'(ADDR_HI));
  assign wmask_ok = (icb_cmd_wmask[1:0] == 2'b11);
  assign reg_idx  = IDX_W'(icb_cmd_addr >> 2);
  assign wr_ok    = accept && !icb_cmd_read && addr_ok && wmask_ok;
  assign err_c    = !addr_ok || (!icb_cmd_read && !wmask_ok);
  assign stat_clr = (wr_ok && reg_idx == IDX_W'(3)) ? icb_cmd_wdata[1:0] : 2'b00;

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      IDX_W'(0): rd_val = tmr_con;
      IDX_W'(1): rd_val = tmr_prd;
      IDX_W'(2): rd_val = tmr_cnt;
      IDX_W'(3): rd_val = {14'd0, stat_q};
      IDX_W'(4): rd_val = {14'd0, ien_q};
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RESP;
      RESP:    if (icb_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response, strobes, STAT/IEN and irq registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_err   <= 1'b0;
      icb_rsp_rdata <= '0;
      con_wr_q      <= 1'b0;
      prd_wr_q      <= 1'b0;
      cnt_wr_q      <= 1'b0;
      icb_wdat      <= '0;
      stat_q        <= '0;
      ien_q         <= '0;
      irq           <= 1'b0;
    end else begin
      irq      <= |(stat_q & ien_q);
      stat_q   <= (stat_q & ~stat_clr) | {tmr_int, tmr_ovf};
      con_wr_q <= wr_ok && (reg_idx == IDX_W'(0));
      prd_wr_q <= wr_ok && (reg_idx == IDX_W'(1));
      cnt_wr_q <= wr_ok && (reg_idx == IDX_W'(2));
      if (wr_ok && reg_idx < IDX_W'(3)) icb_wdat <= icb_cmd_wdata[15:0];
      if (wr_ok && reg_idx == IDX_W'(4)) ien_q <= icb_cmd_wdata[1:0];
      if (accept) begin
        icb_rsp_valid <= 1'b1;
        icb_rsp_err   <= err_c;
        icb_rsp_rdata <= (icb_cmd_read && addr_ok) ? {16'h0000, rd_val} : 32'h0;
      end else if (icb_rsp_valid && icb_rsp_ready) begin
        icb_rsp_valid <= 1'b0;
      end
    end
  end

  // A reset landing in the strobe cycle masks the strobe
  assign tmr_con_wr = con_wr_q && !sys_rst;
  assign tmr_prd_wr = prd_wr_q && !sys_rst;
  assign tmr_cnt_wr = cnt_wr_q && !sys_rst;

endmodule
